decm: RTL

- Decode stage of the ECAP5-DPROC pipeline, directly downstream of the instruction fetch stage.
- Accepts {instr, pc} over a valid/ready handshake and decodes the RV32I instruction.
- Produces register addresses, a sign-extended immediate, the ALU operation, the execution unit select and an illegal-instruction flag for the execute stage, registered with one cycle of latency.
- Supports a pipeline flush on jump.

---
 rtl/ecap5_dproc_pkg.sv | 91 +++++++++
 rtl/decm_imm.sv | 27 ++
 rtl/decm.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared ECAP5-DPROC definitions: RV32I opcodes, ALU operations, execution
// unit select, instruction formats and the decode bundle passed to execute.
package ecap5_dproc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    UNIT_ALU    = 3'd0,
    UNIT_BRANCH = 3'd1,
    UNIT_LOAD   = 3'd2,
    UNIT_STORE  = 3'd3,
    UNIT_SYSTEM = 3'd4,
    UNIT_NONE   = 3'd5
  } unit_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_format_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } decm_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm;
    alu_op_t           alu_op;
    unit_t             unit_sel;
    logic [2:0]        funct3;
    logic              illegal;
  } decm_bundle_t;

  localparam decm_bundle_t BUNDLE_RST = '{
    pc: '0, rs1: '0, rs2: '0, rd: '0, imm: '0,
    alu_op: ALU_ADD, unit_sel: UNIT_NONE, funct3: '0, illegal: 1'b0
  };

  // alt is instr[30] already qualified by the caller (only SUB/SRA use it).
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decm_imm.sv
// Immediate extraction for the decode stage (purely combinational).
// Ports: instr_i - instruction bits [31:7] (opcode bits carry no immediate),
//        fmt_i   - decoded instruction format,
//        imm_o   - sign-extended immediate (0 for R-type).
module decm_imm
  import ecap5_dproc_pkg::*;
(
  input  logic [31:7]      instr_i,
  input  instr_format_t    fmt_i,
  output logic [XLEN-1:0]  imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      FMT_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      FMT_U:   imm_o = {instr_i[31:12], 12'h000};
      FMT_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decm.sv
// ECAP5-DPROC decode stage: decodes one RV32I instruction per transfer and
// presents the registered bundle to execute one cycle later.
// Ports: clk_i/rst_ni (async active-low), jump_i flush, input handshake
//        (input_valid_i/input_ready_o, instr_i, pc_i), output handshake
//        (output_valid_o/output_ready_i) and the decoded fields pc_o, rs1_o,
//        rs2_o, rd_o, imm_o, alu_op_o, unit_o, funct3_o, illegal_o.
// Build option: DECM_SKID_BUFFER_EN adds a second entry so that
//        input_ready_o is a flop with no path from output_ready_i.
module decm
  import ecap5_dproc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              jump_i,
  input  logic              input_valid_i,
  output logic              input_ready_o,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              output_valid_o,
  input  logic              output_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [3:0]        alu_op_o,
  output logic [2:0]        unit_o,
  output logic [2:0]        funct3_o,
  output logic              illegal_o
);

  decm_state_t   state_q, state_d;
  decm_bundle_t  out_q, out_d;
  decm_bundle_t  dec_c, bundle_c;
  instr_format_t fmt_c;
  logic [XLEN-1:0] imm_c;
  logic          alt_c;
  logic          in_fire_c, out_fire_c;
`ifdef DECM_SKID_BUFFER_EN
  decm_bundle_t  skid_q, skid_d;
  logic          ready_q, ready_d;
`endif

  // Decode table. Compressed encodings (instr[1:0] != 2'b11) never match a
  // listed opcode, so they land in the illegal default.
  always_comb begin
    dec_c        = BUNDLE_RST;
    fmt_c        = FMT_R;
    alt_c        = 1'b0;
    dec_c.pc     = pc_i;
    dec_c.rs1    = instr_i[19:15];
    dec_c.rs2    = instr_i[24:20];
    dec_c.rd     = instr_i[11:7];
    dec_c.funct3 = instr_i[14:12];
    case (instr_i[6:0])
      OPCODE_OP: begin
        fmt_c          = FMT_R;
        dec_c.unit_sel = UNIT_ALU;
        alt_c          = instr_i[30];
        dec_c.alu_op   = alu_op_decode(instr_i[14:12], alt_c);
        dec_c.illegal  = !((instr_i[31:25] == 7'b0000000) ||
                           ((instr_i[31:25] == 7'b0100000) &&
                            ((instr_i[14:12] == 3'b000) || (instr_i[14:12] == 3'b101))));
      end
      OPCODE_OP_IMM: begin
        fmt_c          = FMT_I;
        dec_c.unit_sel = UNIT_ALU;
        // No SUBI: instr[30] only distinguishes SRAI from SRLI.
        alt_c          = (instr_i[14:12] == 3'b101) && instr_i[30];
        dec_c.alu_op   = alu_op_decode(instr_i[14:12], alt_c);
        dec_c.illegal  = ((instr_i[14:12] == 3'b001) || (instr_i[14:12] == 3'b101)) &&
                         instr_i[25];
      end
      OPCODE_LUI: begin
        fmt_c          = FMT_U;
        dec_c.unit_sel = UNIT_ALU;
        dec_c.rs1      = '0;
      end
      OPCODE_AUIPC: begin
        fmt_c          = FMT_U;
        dec_c.unit_sel = UNIT_ALU;
      end
      OPCODE_JAL: begin
        fmt_c          = FMT_J;
        dec_c.unit_sel = UNIT_BRANCH;
      end
      OPCODE_JALR: begin
        fmt_c          = FMT_I;
        dec_c.unit_sel = UNIT_BRANCH;
      end
      OPCODE_BRANCH: begin
        fmt_c          = FMT_B;
        dec_c.unit_sel = UNIT_BRANCH;
        dec_c.rd       = '0;
      end
      OPCODE_LOAD: begin
        fmt_c          = FMT_I;
        dec_c.unit_sel = UNIT_LOAD;
      end
      OPCODE_STORE: begin
        fmt_c          = FMT_S;
        dec_c.unit_sel = UNIT_STORE;
        dec_c.rd       = '0;
      end
      OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
        fmt_c          = FMT_I;
        dec_c.unit_sel = UNIT_SYSTEM;
      end
      default: dec_c.illegal = 1'b1;
    endcase
    // Illegal encodings carry no write, no immediate and a neutral ALU op.
    if (dec_c.illegal) begin
      fmt_c          = FMT_R;
      dec_c.unit_sel = UNIT_NONE;
      dec_c.rd       = '0;
      dec_c.alu_op   = ALU_ADD;
    end
  end

  decm_imm u_imm (
    .instr_i (instr_i[31:7]),
    .fmt_i   (fmt_c),
    .imm_o   (imm_c)
  );

  // Full bundle as captured on an input transfer.
  always_comb begin
    bundle_c     = dec_c;
    bundle_c.imm = imm_c;
  end

`ifdef DECM_SKID_BUFFER_EN
  assign input_ready_o = ready_q;
`else
  assign input_ready_o = (state_q == ST_EMPTY) || output_ready_i;
`endif
  assign output_valid_o = (state_q != ST_EMPTY);
  assign in_fire_c      = input_valid_i && input_ready_o;
  assign out_fire_c     = output_valid_o && output_ready_i;

  // Handshake next-state; jump_i overrides every other event.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef DECM_SKID_BUFFER_EN
    skid_d  = skid_q;
`endif
    if (jump_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_c) begin
            state_d = ST_FULL;
            out_d   = bundle_c;
          end
        end
        ST_FULL: begin
          if (in_fire_c && out_fire_c) begin
            out_d = bundle_c;
`ifdef DECM_SKID_BUFFER_EN
          end else if (in_fire_c) begin
            state_d = ST_SKID;
            skid_d  = bundle_c;
`endif
          end else if (out_fire_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire_c) begin
            state_d = ST_FULL;
`ifdef DECM_SKID_BUFFER_EN
            out_d   = skid_q;
`endif
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
`ifdef DECM_SKID_BUFFER_EN
    ready_d = (state_d != ST_SKID);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      out_q   <= BUNDLE_RST;
`ifdef DECM_SKID_BUFFER_EN
      skid_q  <= BUNDLE_RST;
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
`ifdef DECM_SKID_BUFFER_EN
      skid_q  <= skid_d;
      ready_q <= ready_d;
`endif
    end
  end

  assign pc_o      = out_q.pc;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign rd_o      = out_q.rd;
  assign imm_o     = out_q.imm;
  assign alu_op_o  = out_q.alu_op;
  assign unit_o    = out_q.unit_sel;
  assign funct3_o  = out_q.funct3;
  assign illegal_o = out_q.illegal;

endmodule
